// File: rtl/gcd_pkg.sv
// Shared types and constants for the parametrised GCD engine.
// State encoding is fixed so the debug State output has a stable meaning.
package gcd_pkg;

    typedef enum logic [1:0] {
        S_WAITX = 2'd0,
        S_WAITY = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

    // The shift count k reaches at most WIDTH-1, so one spare bit is enough.
    function automatic int kWidth(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_engine_p_if.sv
// Operand/result bus of the GCD engine: the Enter/Input/Mode front-end and
// the Output/Halt/Busy/Error/Cycles/State status seen by the driving bench.
interface gcd_engine_p_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             enter;
    logic [WIDTH-1:0] dataIn;
    logic             mode;
    logic [WIDTH-1:0] result;
    logic             halt;
    logic             busy;
    logic             error;
    logic [CNT_W-1:0] cycles;
    logic [1:0]       state;

    modport master (
        output enter, dataIn, mode,
        input  result, halt, busy, error, cycles, state
    );

    modport slave (
        input  enter, dataIn, mode,
        output result, halt, busy, error, cycles, state
    );
endinterface

// File: rtl/gcd_datapath.sv
// X/Y/k registers and the per-cycle GCD step for both algorithms.
// Termination flags and the finished result go back to the controlling FSM.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             loadX_i,
    input  logic             loadY_i,
    input  logic             step_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             xZero_o,
    output logic             yZero_o,
    output logic             eq_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int KW = kWidth(WIDTH);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [KW-1:0]    k_q, k_d;
    logic             mode_q, mode_d;
    logic             done;

    assign xZero_o = (x_q == '0);
    assign yZero_o = (y_q == '0);
    assign eq_o    = (x_q == y_q);
    assign done    = xZero_o | yZero_o | eq_o;

    always_comb begin
        result_o = x_q;
        if (xZero_o) begin
            result_o = y_q;
        end else if (yZero_o) begin
            result_o = x_q;
        end else if (mode_q == MODE_BIN) begin
            result_o = x_q << k_q;
        end
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        k_d    = k_q;
        mode_d = mode_q;
        if (loadX_i) begin
            x_d = data_i;
        end else if (loadY_i) begin
            y_d    = data_i;
            mode_d = mode_i;
            k_d    = '0;
        end else if (step_i && !done) begin
            if (mode_q == MODE_SUB) begin
                if (x_q > y_q) begin
                    x_d = x_q - y_q;
                end else begin
                    y_d = y_q - x_q;
                end
            end else begin
                // Stein: strip common twos into k, then odd factors, then subtract.
                if (!x_q[0] && !y_q[0]) begin
                    x_d = x_q >> 1;
                    y_d = y_q >> 1;
                    k_d = k_q + KW'(1);
                end else if (!x_q[0]) begin
                    x_d = x_q >> 1;
                end else if (!y_q[0]) begin
                    y_d = y_q >> 1;
                end else if (x_q > y_q) begin
                    x_d = x_q - y_q;
                end else begin
                    y_d = y_q - x_q;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q    <= '0;
            y_q    <= '0;
            k_q    <= '0;
            mode_q <= MODE_SUB;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            k_q    <= k_d;
            mode_q <= mode_d;
        end
    end

endmodule

// File: rtl/gcd_engine_p.sv
// GCD engine top: Enter edge detect, control FSM, result/error registers and
// saturating run-cycle counter around the gcd_datapath step unit.
module gcd_engine_p
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    gcd_engine_p_if.slave  bus
);

    state_t           state_q, state_d;
    logic             enter_q;
    logic             enterEdge;
    logic [WIDTH-1:0] result_q, result_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             loadX, loadY, step;
    logic             xZero, yZero, eq;
    logic [WIDTH-1:0] dpResult;

    // Only a 0->1 change captures, so a held Enter loads exactly once.
    assign enterEdge = bus.enter & ~enter_q;

    gcd_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .loadX_i  (loadX),
        .loadY_i  (loadY),
        .step_i   (step),
        .mode_i   (bus.mode),
        .data_i   (bus.dataIn),
        .xZero_o  (xZero),
        .yZero_o  (yZero),
        .eq_o     (eq),
        .result_o (dpResult)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        error_d  = error_q;
        cycles_d = cycles_q;
        loadX    = 1'b0;
        loadY    = 1'b0;
        step     = 1'b0;
        case (state_q)
            S_WAITX, S_DONE: begin
                if (enterEdge) begin
                    loadX   = 1'b1;
                    state_d = S_WAITY;
                end
            end
            S_WAITY: begin
                if (enterEdge) begin
                    loadY    = 1'b1;
                    cycles_d = '0;
                    error_d  = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + CNT_W'(1);
                end
                if (xZero || yZero || eq) begin
                    result_d = dpResult;
                    error_d  = xZero & yZero;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_WAITX;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_WAITX;
            enter_q  <= 1'b0;
            result_q <= '0;
            error_q  <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            enter_q  <= bus.enter;
            result_q <= result_d;
            error_q  <= error_d;
            cycles_q <= cycles_d;
        end
    end

    assign bus.result = result_q;
    assign bus.halt   = (state_q == S_DONE);
    assign bus.busy   = (state_q == S_RUN);
    assign bus.error  = error_q;
    assign bus.cycles = cycles_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_gcd_engine_p.sv
// Self-checking bench for gcd_engine_p at WIDTH=8 and WIDTH=16, comparing
// against a Euclid-based reference model with directed and random operands.
module tb_gcd_engine_p;

    logic clk;
    logic rstN;
    int   checks;
    int   errors;

    gcd_engine_p_if #(.WIDTH(8),  .CNT_W(16)) bus8 ();
    gcd_engine_p_if #(.WIDTH(16), .CNT_W(16)) bus16 ();

    gcd_engine_p #(.WIDTH(8), .CNT_W(16)) dut8 (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (bus8)
    );

    gcd_engine_p #(.WIDTH(16), .CNT_W(16)) dut16 (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned gcdRef(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // The subtraction algorithm spends one cycle per unit of Euclid quotient.
    function automatic int unsigned quotSum(input int unsigned a, input int unsigned b);
        int unsigned s;
        int unsigned t;
        s = 0;
        while (b != 0) begin
            s += a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
        end
    endtask

    task automatic driveIn(input int sel, input logic en, input logic [15:0] data, input logic m);
        if (sel == 0) begin
            bus8.enter  = en;
            bus8.dataIn = data[7:0];
            bus8.mode   = m;
        end else begin
            bus16.enter  = en;
            bus16.dataIn = data;
            bus16.mode   = m;
        end
    endtask

    task automatic readOut(input int sel, output logic [31:0] res, output logic [31:0] halt,
                           output logic [31:0] busy, output logic [31:0] err,
                           output logic [31:0] cyc, output logic [31:0] st);
        if (sel == 0) begin
            res = 32'(bus8.result);  halt = 32'(bus8.halt);  busy = 32'(bus8.busy);
            err = 32'(bus8.error);   cyc  = 32'(bus8.cycles); st  = 32'(bus8.state);
        end else begin
            res = 32'(bus16.result); halt = 32'(bus16.halt); busy = 32'(bus16.busy);
            err = 32'(bus16.error);  cyc  = 32'(bus16.cycles); st = 32'(bus16.state);
        end
    endtask

    // Loads X then Y, then scrambles Mode/Input while the engine runs.
    task automatic applyStimulus(input int sel, input logic [15:0] x, input logic [15:0] y, input logic m);
        @(negedge clk); driveIn(sel, 1'b1, x, m);
        @(negedge clk); driveIn(sel, 1'b0, x, m);
        @(negedge clk); driveIn(sel, 1'b1, y, m);
        @(negedge clk); driveIn(sel, 1'b0, 16'($urandom), ~m);
    endtask

    task automatic waitHalt(input int sel);
        logic [31:0] res, halt, busy, err, cyc, st;
        logic        seen;
        seen = 1'b0;
        for (int i = 0; i < 70000 && !seen; i++) begin
            @(negedge clk);
            readOut(sel, res, halt, busy, err, cyc, st);
            if (halt == 1) seen = 1'b1;
        end
        checkOutput("haltSeen", 32'(seen), 32'd1);
    endtask

    task automatic runPair(input int sel, input logic [15:0] x, input logic [15:0] y, input logic m,
                           output logic [31:0] res, output logic [31:0] err, output logic [31:0] cyc);
        logic [31:0] halt, busy, st;
        applyStimulus(sel, x, y, m);
        readOut(sel, res, halt, busy, err, cyc, st);
        checkOutput("busyInRun", busy, 32'd1);
        waitHalt(sel);
        readOut(sel, res, halt, busy, err, cyc, st);
    endtask

    initial begin
        logic [31:0] res, halt, busy, err, cyc, st;
        int unsigned a, b, g, maxv;
        checks = 0;
        errors = 0;
        rstN = 1'b0;
        driveIn(0, 1'b0, 16'd0, 1'b0);
        driveIn(1, 1'b0, 16'd0, 1'b0);
        #12 rstN = 1'b1;

        @(negedge clk);
        readOut(0, res, halt, busy, err, cyc, st);
        checkOutput("rstResult", res, 0);
        checkOutput("rstHalt", halt, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstError", err, 0);
        checkOutput("rstCycles", cyc, 0);
        checkOutput("rstState", st, 0);

        runPair(0, 16'd12, 16'd18, 1'b0, res, err, cyc);
        checkOutput("sub12_18", res, 6);
        checkOutput("sub12_18cyc", cyc, 3);
        checkOutput("sub12_18err", err, 0);

        runPair(0, 16'd12, 16'd18, 1'b1, res, err, cyc);
        checkOutput("bin12_18", res, 6);
        checkOutput("bin12_18cyc", cyc, 5);

        runPair(0, 16'd1, 16'd255, 1'b0, res, err, cyc);
        checkOutput("sub1_255", res, 1);
        checkOutput("sub1_255cyc", cyc, 255);

        runPair(0, 16'd1, 16'd255, 1'b1, res, err, cyc);
        checkOutput("bin1_255", res, 1);
        checkOutput("bin1_255fast", 32'(cyc < 32), 1);

        runPair(0, 16'd0, 16'd40, 1'b0, res, err, cyc);
        checkOutput("zeroX", res, 40);
        checkOutput("zeroXcyc", cyc, 1);
        checkOutput("zeroXerr", err, 0);

        runPair(0, 16'd0, 16'd0, 1'b1, res, err, cyc);
        checkOutput("bothZero", res, 0);
        checkOutput("bothZeroErr", err, 1);
        checkOutput("bothZeroCyc", cyc, 1);

        // Held Enter for X, then a stray pulse with junk data while running.
        @(negedge clk); driveIn(0, 1'b1, 16'd9, 1'b0);
        repeat (5) @(negedge clk);
        driveIn(0, 1'b0, 16'd9, 1'b0);
        @(negedge clk); driveIn(0, 1'b1, 16'd6, 1'b0);
        @(negedge clk); driveIn(0, 1'b0, 16'd6, 1'b0);
        @(negedge clk); driveIn(0, 1'b1, 16'd50, 1'b0);
        @(negedge clk); driveIn(0, 1'b0, 16'd50, 1'b0);
        waitHalt(0);
        repeat (3) @(negedge clk);
        readOut(0, res, halt, busy, err, cyc, st);
        checkOutput("heldEnter", res, 3);
        checkOutput("heldEnterCyc", cyc, 3);
        checkOutput("runPulseIgnored", st, 3);

        applyStimulus(0, 16'd100, 16'd3, 1'b0);
        repeat (5) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        readOut(0, res, halt, busy, err, cyc, st);
        checkOutput("midRstResult", res, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstCycles", cyc, 0);
        checkOutput("midRstState", st, 0);
        checkOutput("midRstHalt", halt, 0);
        #5 rstN = 1'b1;
        runPair(0, 16'd21, 16'd14, 1'b0, res, err, cyc);
        checkOutput("afterRst", res, 7);

        for (int sel = 0; sel < 2; sel++) begin
            maxv = (sel == 0) ? 255 : 65535;
            for (int m = 0; m < 2; m++) begin
                for (int n = 0; n < 100; n++) begin
                    g = $urandom_range(1, 12);
                    a = g * $urandom_range(1, maxv / g);
                    b = g * $urandom_range(1, maxv / g);
                    for (int t = 0; t < 100 && m == 0 && quotSum(a, b) > 150; t++) begin
                        a = g * $urandom_range(1, maxv / g);
                        b = g * $urandom_range(1, maxv / g);
                    end
                    runPair(sel, 16'(a), 16'(b), 1'(m), res, err, cyc);
                    checkOutput("randGcd", res, gcdRef(a, b));
                    checkOutput("randErr", err, 0);
                    if (m == 0) checkOutput("randSubCyc", cyc, quotSum(a, b));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gcd_engine_p.md
Name: gcd_engine_p

Overview:
Parametrised successor to the single-width GCD processor. Operands are entered serially on one input bus with an Enter strobe. GCD is computed by either the subtraction algorithm or the binary (Stein) algorithm. The result is presented with a Halt flag, zero-operand error detection and a compute-cycle count. It sits behind the same Enter/Input/Output/Halt front-end the processor benches already drive.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
CNT_W, 16, width of the Cycles counter (saturating)

Ports:
Clock  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
Enter  input  1  operand strobe; a rising edge (0->1 between consecutive Clock samples) captures Input
Input  input  WIDTH  operand data, sampled on the Enter edge
Mode  input  1  0 = subtraction GCD, 1 = binary GCD; sampled on the Y-capture edge
Output  output  WIDTH  GCD result, valid while Halt=1
Halt  output  1  computation finished
Busy  output  1  high in S_RUN
Error  output  1  both operands were zero
Cycles  output  CNT_W  number of S_RUN cycles spent on the last computation
State  output  2  current state encoding, for debug

Behaviour:
- Interface: one clock (Clock); Reset is asynchronous, active-low.
- Reset (any time, including mid-computation):
  - State=S_WAITX; Output=0, Halt=0, Busy=0, Error=0, Cycles=0.
  - Internal X, Y and shift count k cleared; Enter-edge register cleared.
- Enter edge detect:
  - Registered copy of Enter; edge = Enter & ~Enter_q.
  - An Enter held high for many cycles captures exactly once.
- S_WAITX: on edge -> X<=Input, go S_WAITY.
- S_WAITY: on edge:
  - Y<=Input, latch Mode, k<=0, Cycles<=0, Halt<=0, Error<=0, go S_RUN.
- S_RUN: one step per cycle; Cycles increments every cycle, saturating at all-ones. Checks in priority order:
  1. X==0 && Y==0: Output<=0, Error<=1 -> S_DONE.
  2. X==0: Output<=Y -> S_DONE.
  3. Y==0: Output<=X -> S_DONE.
  4. X==Y: Output<=X (mode 0) or X<<k (mode 1, truncated to WIDTH; cannot overflow since result <= max operand) -> S_DONE.
  5. Mode 0: if X>Y then X<=X-Y, else Y<=Y-X.
  6. Mode 1:
     - both even: X>>=1, Y>>=1, k++.
     - else X even: X>>=1.
     - else Y even: Y>>=1.
     - else larger <= larger - smaller.
- S_DONE: Halt=1 and Output held stable.
  - On an Enter edge: X<=Input, Halt<=0 -> S_WAITY (new computation; old Output holds until overwritten at the next completion).
- Enter edges during S_RUN are ignored. Input and Mode changes during S_RUN have no effect.
- Latency: Halt rises on the Clock edge after the terminating S_RUN cycle. Cycles includes that terminating cycle.
- k width = clog2(WIDTH)+1; k never exceeds WIDTH-1.
- Outputs Halt, Busy and State are registered/decoded directly from state. There are no combinational paths from Input to outputs.

Decomposition:
- Shared package gcd_pkg:
  - state localparams S_WAITX=2'd0, S_WAITY=2'd1, S_RUN=2'd2, S_DONE=2'd3.
  - mode constants MODE_SUB=1'b0, MODE_BIN=1'b1.
- One sub-module gcd_datapath (parametrised WIDTH):
  - holds the X, Y, k registers and the step logic.
  - reports eq/zero flags to the FSM in gcd_engine_p.
  - the FSM, edge detect and Cycles counter stay in the top module.

Test Plan:
- Mode 0, X=12, Y=18 -> Halt after 3 RUN cycles, Output=6, Cycles=3, Error=0.
- Mode 1, X=12, Y=18 -> Output=6, Cycles=5 (steps: 6,9,k=1; 3,9; 3,6; 3,3; done).
- Mode 0, WIDTH=8, X=1, Y=255 -> Output=1, Cycles=255. Mode 1, same operands -> Output=1 with Cycles far smaller.
- Zero operands:
  - X=0, Y=40 -> Output=40, Cycles=1.
  - X=0, Y=0 -> Output=0, Error=1, Cycles=1.
- Enter held high 5 cycles for X=9, then a pulse for Y=6 -> exactly one capture each, Output=3. An extra Enter pulse during S_RUN is ignored.
- Reset pulled low mid-S_RUN (X=100, Y=3) -> all outputs 0 immediately (asynchronous). After release, a new pair 21, 14 -> Output=7. Repeat 100 random nonzero pairs per mode, WIDTH=8 and WIDTH=16, against a reference GCD model.
